// File: rtl/avalon_arbiter_if.sv
// Basic-mode Avalon-MM link (no pipelining, no burst) between one master and one slave.
// The arbiter uses the slave modport toward each requester and the master modport toward the shared slave.
interface avalon_arbiter_if #(
    parameter int unsigned NBADDRBITS  = 8,
    parameter int unsigned NBDATABYTES = 2
) ();
    logic [NBADDRBITS-1:0]    address;
    logic [NBDATABYTES-1:0]   byteenable;
    logic                     read;
    logic                     write;
    logic [8*NBDATABYTES-1:0] writedata;
    logic [8*NBDATABYTES-1:0] readdata;
    logic                     waitrequest;

    modport master (
        output address, byteenable, read, write, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output readdata, waitrequest
    );
endinterface

// File: rtl/avalon_arbiter.sv
// Two-master round-robin arbiter for one shared Avalon-MM slave, with a waitrequest
// timeout abort and a pulse on masters that raise read and write together.
module avalon_arbiter #(
    parameter int unsigned NBADDRBITS  = 8,
    parameter int unsigned NBDATABYTES = 2,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic             clk,
    input  logic             rst,
    avalon_arbiter_if.slave  m0,
    avalon_arbiter_if.slave  m1,
    avalon_arbiter_if.master s,
    output logic [1:0]       grant,
    output logic             timeout_err,
    output logic             proto_err
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StBus0, StBus1} state_e;

    state_e          state_q, state_d;
    logic            last_gnt_q, last_gnt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      grant_q;
    logic            proto_err_q;
    logic            bad0_q, bad1_q;

    logic req0, req1, bad0, bad1;
    logic in_bus, sel1, req_sel, req_oth;
    logic abort, done;

    assign req0 = m0.read ^ m0.write;
    assign req1 = m1.read ^ m1.write;
    assign bad0 = m0.read & m0.write;
    assign bad1 = m1.read & m1.write;

    assign in_bus  = (state_q == StBus0) || (state_q == StBus1);
    assign sel1    = (state_q == StBus1);
    assign req_sel = sel1 ? req1 : req0;
    assign req_oth = sel1 ? req0 : req1;

    // Abort on the TIMEOUT-th consecutive stalled cycle; a dropped request is not aborted.
    assign abort = in_bus && req_sel && s.waitrequest && (cnt_q == CW'(TIMEOUT - 1));
    assign done  = in_bus && req_sel && (!s.waitrequest || abort);

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req0 && req1) begin
                    state_d = last_gnt_q ? StBus0 : StBus1;
                end else if (req0) begin
                    state_d = StBus0;
                end else if (req1) begin
                    state_d = StBus1;
                end
            end
            StBus0, StBus1: begin
                if (done) begin
                    last_gnt_d = sel1;
                    if (req_oth) begin
                        state_d = sel1 ? StBus0 : StBus1;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (!req_sel) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (in_bus && s.waitrequest && (cnt_q != CW'(TIMEOUT))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            last_gnt_q  <= 1'b1;
            cnt_q       <= '0;
            grant_q     <= 2'b00;
            proto_err_q <= 1'b0;
            bad0_q      <= 1'b0;
            bad1_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            cnt_q       <= cnt_d;
            grant_q     <= (state_d == StBus0) ? 2'b01 :
                           (state_d == StBus1) ? 2'b10 : 2'b00;
            // Pulse once per offending episode rather than every cycle it persists.
            proto_err_q <= (bad0 && !bad0_q) || (bad1 && !bad1_q);
            bad0_q      <= bad0;
            bad1_q      <= bad1;
        end
    end

    always_comb begin
        s.address      = '0;
        s.byteenable   = '0;
        s.read         = 1'b0;
        s.write        = 1'b0;
        s.writedata    = '0;
        m0.waitrequest = 1'b1;
        m0.readdata    = '0;
        m1.waitrequest = 1'b1;
        m1.readdata    = '0;
        unique case (state_q)
            StBus0: begin
                s.address      = m0.address;
                s.byteenable   = m0.byteenable;
                s.writedata    = m0.writedata;
                s.read         = m0.read && req0 && !abort;
                s.write        = m0.write && req0 && !abort;
                m0.waitrequest = s.waitrequest && !abort;
                m0.readdata    = abort ? '1 : s.readdata;
            end
            StBus1: begin
                s.address      = m1.address;
                s.byteenable   = m1.byteenable;
                s.writedata    = m1.writedata;
                s.read         = m1.read && req1 && !abort;
                s.write        = m1.write && req1 && !abort;
                m1.waitrequest = s.waitrequest && !abort;
                m1.readdata    = abort ? '1 : s.readdata;
            end
            default: ;
        endcase
    end

    assign grant       = grant_q;
    assign timeout_err = abort;
    assign proto_err   = proto_err_q;
endmodule

// File: tb/tb_avalon_arbiter.sv
// Directed bench for avalon_arbiter: a vector table for single-cycle behaviour plus
// hand-written timeout and asynchronous-reset sequences.
module tb_avalon_arbiter;
    logic       clk;
    logic       rst;
    logic [1:0] grant;
    logic       timeout_err;
    logic       proto_err;

    avalon_arbiter_if #(.NBADDRBITS(8), .NBDATABYTES(2)) m0_if ();
    avalon_arbiter_if #(.NBADDRBITS(8), .NBDATABYTES(2)) m1_if ();
    avalon_arbiter_if #(.NBADDRBITS(8), .NBDATABYTES(2)) s_if ();

    avalon_arbiter #(.NBADDRBITS(8), .NBDATABYTES(2), .TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .m0         (m0_if),
        .m1         (m1_if),
        .s          (s_if),
        .grant      (grant),
        .timeout_err(timeout_err),
        .proto_err  (proto_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // in = {m0_read, m0_write, m1_read, m1_write, s_waitrequest}
    // exp = {grant, m0_wait, m1_wait, s_read, s_write, s_addr, s_wdata, m0_rdata, m1_rdata, to, pe}
    typedef struct packed {
        logic [4:0]  in;
        logic [15:0] srd;
        logic [63:0] exp;
    } vec_t;

    vec_t vq[$];
    int   n_pass  = 0;
    int   n_total = 0;

    localparam logic [63:0] IDLE = {2'b00, 4'b1100, 8'h00, 16'h0000, 16'h0000, 16'h0000, 2'b00};

    function automatic logic [63:0] mk(input logic [1:0] g, input logic [3:0] hs,
                                       input logic [7:0] sa, input logic [15:0] sd,
                                       input logic [15:0] rd0, input logic [15:0] rd1,
                                       input logic [1:0] err);
        return {g, hs, sa, sd, rd0, rd1, err};
    endfunction

    function automatic logic [63:0] obs();
        return {grant, m0_if.waitrequest, m1_if.waitrequest, s_if.read, s_if.write,
                s_if.address, s_if.writedata, m0_if.readdata, m1_if.readdata,
                timeout_err, proto_err};
    endfunction

    task automatic add(input logic [4:0] in, input logic [15:0] srd, input logic [63:0] exp);
        vec_t v;
        v.in  = in;
        v.srd = srd;
        v.exp = exp;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic drive(input logic [4:0] in, input logic [15:0] srd);
        m0_if.read       = in[4];
        m0_if.write      = in[3];
        m1_if.read       = in[2];
        m1_if.write      = in[1];
        s_if.waitrequest = in[0];
        s_if.readdata    = srd;
    endtask

    // Called at posedge+1: apply inputs, sample mid-cycle, advance to next posedge+1.
    task automatic step_check(input string name, input logic [4:0] in, input logic [15:0] srd,
                              input logic [63:0] exp);
        drive(in, srd);
        #4;
        check(name, obs(), exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        m0_if.address    = 8'h10;
        m0_if.byteenable = 2'b11;
        m0_if.writedata  = 16'hAAAA;
        m1_if.address    = 8'h20;
        m1_if.byteenable = 2'b11;
        m1_if.writedata  = 16'h5555;
        drive(5'b00000, 16'h0000);
        rst = 1'b0;

        // Two-way tie after reset, zero-wait slave: m0 then m1, no idle gap.
        add(5'b01010, 16'h0000, IDLE);
        add(5'b01010, 16'h0000, mk(2'b01, 4'b0101, 8'h10, 16'hAAAA, 16'h0000, 16'h0000, 2'b00));
        add(5'b00010, 16'h0000, mk(2'b10, 4'b1001, 8'h20, 16'h5555, 16'h0000, 16'h0000, 2'b00));
        add(5'b00000, 16'h0000, IDLE);
        // m0 read with two stalled cycles.
        add(5'b10001, 16'h1234, IDLE);
        add(5'b10001, 16'h1234, mk(2'b01, 4'b1110, 8'h10, 16'hAAAA, 16'h1234, 16'h0000, 2'b00));
        add(5'b10001, 16'h1234, mk(2'b01, 4'b1110, 8'h10, 16'hAAAA, 16'h1234, 16'h0000, 2'b00));
        add(5'b10000, 16'h1234, mk(2'b01, 4'b0110, 8'h10, 16'hAAAA, 16'h1234, 16'h0000, 2'b00));
        add(5'b00001, 16'h1234, IDLE);
        // Continuous contention: last served was m0, so m1 goes first, then strict alternation.
        add(5'b10100, 16'hBEEF, IDLE);
        for (int i = 1; i <= 8; i++) begin
            if (i % 2 == 1)
                add(5'b10100, 16'hBEEF,
                    mk(2'b10, 4'b1010, 8'h20, 16'h5555, 16'h0000, 16'hBEEF, 2'b00));
            else
                add(5'b10100, 16'hBEEF,
                    mk(2'b01, 4'b0110, 8'h10, 16'hAAAA, 16'hBEEF, 16'h0000, 2'b00));
        end
        add(5'b00000, 16'hBEEF, mk(2'b10, 4'b1000, 8'h20, 16'h5555, 16'h0000, 16'hBEEF, 2'b00));
        add(5'b00000, 16'hBEEF, IDLE);
        // m1 read and write together: one proto_err pulse, never forwarded.
        add(5'b00110, 16'h0000, IDLE);
        add(5'b00110, 16'h0000, IDLE | 64'h1);
        add(5'b00110, 16'h0000, IDLE);
        add(5'b00000, 16'h0000, IDLE);

        #12;
        check("reset_outputs", obs(), IDLE);
        check("reset_byteenable", {62'd0, s_if.byteenable}, 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vq.size(); i++) begin
            step_check($sformatf("vec%0d", i), vq[i].in, vq[i].srd, vq[i].exp);
        end

        // Stuck slave: abort on the 16th stalled cycle of m1's grant.
        for (int k = 0; k <= 17; k++) begin
            logic [63:0] e;
            if (k == 0 || k == 17) e = IDLE;
            else if (k < 16) e = mk(2'b10, 4'b1110, 8'h20, 16'h5555, 16'h0000, 16'h0F0F, 2'b00);
            else e = mk(2'b10, 4'b1000, 8'h20, 16'h5555, 16'h0000, 16'hFFFF, 2'b10);
            step_check($sformatf("timeout_k%0d", k), (k <= 16) ? 5'b00101 : 5'b00001,
                       16'h0F0F, e);
        end

        // Serve m0 so the round-robin pointer favours m1, then reset mid-grant.
        step_check("t6_pre0", 5'b10000, 16'h0000, IDLE);
        step_check("t6_pre1", 5'b10000, 16'h0000,
                   mk(2'b01, 4'b0110, 8'h10, 16'hAAAA, 16'h0000, 16'h0000, 2'b00));
        step_check("t6_pre2", 5'b00001, 16'h0000, IDLE);
        step_check("t6_stall0", 5'b10001, 16'h4321, IDLE);
        step_check("t6_stall1", 5'b10001, 16'h4321,
                   mk(2'b01, 4'b1110, 8'h10, 16'hAAAA, 16'h4321, 16'h0000, 2'b00));
        #2;
        rst = 1'b0;
        #1;
        check("t6_async", obs(), IDLE);
        check("t6_async_be", {62'd0, s_if.byteenable}, 64'd0);
        @(posedge clk);
        #2;
        check("t6_held", obs(), IDLE);
        drive(5'b00000, 16'h0000);
        rst = 1'b1;
        @(posedge clk);
        #1;
        step_check("t6_tie0", 5'b10100, 16'h0000, IDLE);
        step_check("t6_tie1", 5'b10100, 16'h0000,
                   mk(2'b01, 4'b0110, 8'h10, 16'hAAAA, 16'h0000, 16'h0000, 2'b00));
        step_check("t6_tie2", 5'b00000, 16'h0000,
                   mk(2'b10, 4'b1000, 8'h20, 16'h5555, 16'h0000, 16'h0000, 2'b00));
        step_check("t6_tie3", 5'b00000, 16'h0000, IDLE);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
